// File: rtl/fp_class_pipe.sv
// Multi-lane IEEE-754 operand classifier behind a valid/ready pipeline.
// Sticky exception flags and saturating NaN/Inf counters are updated from delivered beats.
module fp_class_pipe #(
    parameter int SIGN_W      = 1,
    parameter int EXPO_W      = 8,
    parameter int MANT_W      = 23,
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [LANES*(SIGN_W+EXPO_W+MANT_W)-1:0] in_data,
    input  logic [LANES-1:0]                       in_lane_mask,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [LANES*6-1:0]                     out_class,
    output logic [LANES-1:0]                       out_sign,
    output logic [LANES-1:0]                       out_max_expo,
    output logic                                   sticky_nan,
    output logic                                   sticky_snan,
    output logic                                   sticky_inf,
    output logic [CNT_W-1:0]                       nan_cnt,
    output logic [CNT_W-1:0]                       inf_cnt,
    input  logic                                   stat_clr
);

    localparam int FP_W  = SIGN_W + EXPO_W + MANT_W;
    localparam int LAST  = PIPE_STAGES - 1;
    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshake: a beat moves across a boundary on a cycle where valid and ready are
    // both high; a producer holding valid keeps its payload unchanged until ready.

    // Classification of the incoming beat
    logic [LANES*6-1:0] cls_d;
    logic [LANES-1:0]   sign_d;
    logic [LANES-1:0]   maxe_d;

    always_comb begin
        logic [FP_W-1:0]   lane;
        logic [EXPO_W-1:0] expo;
        logic [MANT_W-1:0] mant;
        logic [5:0]        c;
        cls_d  = '0;
        sign_d = '0;
        maxe_d = '0;
        lane   = '0;
        expo   = '0;
        mant   = '0;
        c      = '0;
        for (int k = 0; k < LANES; k++) begin
            lane = in_data[k*FP_W +: FP_W];
            expo = lane[MANT_W +: EXPO_W];
            mant = lane[MANT_W-1:0];
            c    = 6'b000000;
            if (in_lane_mask[k]) begin
                if (expo == '0)
                    c = (mant == '0) ? 6'b000001 : 6'b000010;
                else if (&expo) begin
                    if (mant == '0)
                        c = 6'b001000;
                    else if (mant[MANT_W-1])
                        c = 6'b010000;
                    else
                        c = 6'b100000;
                end else
                    c = 6'b000100;
                sign_d[k] = lane[FP_W-1];
                maxe_d[k] = &expo;
            end
            cls_d[k*6 +: 6] = c;
        end
    end

    // Pipeline stages
    logic [PIPE_STAGES-1:0] vld;
    logic [PIPE_STAGES-1:0] adv;
    logic [LANES*6-1:0]     cls_q  [PIPE_STAGES];
    logic [LANES-1:0]       sign_q [PIPE_STAGES];
    logic [LANES-1:0]       maxe_q [PIPE_STAGES];
    logic                   accept;

    always_comb begin
        adv       = '0;
        adv[LAST] = vld[LAST] & out_ready;
        for (int k = LAST - 1; k >= 0; k--)
            adv[k] = vld[k] & (~vld[k+1] | adv[k+1]);
    end

    assign in_ready = ~vld[0] | adv[0];
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                cls_q[k]  <= '0;
                sign_q[k] <= '0;
                maxe_q[k] <= '0;
            end
        end else begin
            vld[0] <= accept | (vld[0] & ~adv[0]);
            if (accept) begin
                cls_q[0]  <= cls_d;
                sign_q[0] <= sign_d;
                maxe_q[0] <= maxe_d;
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                vld[k] <= adv[k-1] | (vld[k] & ~adv[k]);
                if (adv[k-1]) begin
                    cls_q[k]  <= cls_q[k-1];
                    sign_q[k] <= sign_q[k-1];
                    maxe_q[k] <= maxe_q[k-1];
                end
            end
        end
    end

    assign out_valid    = vld[LAST];
    assign out_class    = cls_q[LAST];
    assign out_sign     = sign_q[LAST];
    assign out_max_expo = maxe_q[LAST];

    // Statistics from the beat leaving the last stage
    logic             out_hs;
    logic [PC_W-1:0]  nan_pop;
    logic [PC_W-1:0]  inf_pop;
    logic             any_nan;
    logic             any_snan;
    logic             any_inf;
    logic [SUM_W-1:0] nan_sum;
    logic [SUM_W-1:0] inf_sum;
    logic [CNT_W-1:0] nan_next;
    logic [CNT_W-1:0] inf_next;

    assign out_hs = vld[LAST] & out_ready;

    always_comb begin
        nan_pop  = '0;
        inf_pop  = '0;
        any_nan  = 1'b0;
        any_snan = 1'b0;
        any_inf  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            nan_pop  = nan_pop + PC_W'(out_class[k*6+4] | out_class[k*6+5]);
            inf_pop  = inf_pop + PC_W'(out_class[k*6+3]);
            any_nan  = any_nan | out_class[k*6+4] | out_class[k*6+5];
            any_snan = any_snan | out_class[k*6+5];
            any_inf  = any_inf | out_class[k*6+3];
        end
        nan_sum  = SUM_W'(nan_cnt) + SUM_W'(nan_pop);
        inf_sum  = SUM_W'(inf_cnt) + SUM_W'(inf_pop);
        nan_next = (nan_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : nan_sum[CNT_W-1:0];
        inf_next = (inf_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : inf_sum[CNT_W-1:0];
    end

    // A clear wins over a coincident delivery; that beat's events are simply not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_nan  <= 1'b0;
            sticky_snan <= 1'b0;
            sticky_inf  <= 1'b0;
            nan_cnt     <= '0;
            inf_cnt     <= '0;
        end else if (stat_clr) begin
            sticky_nan  <= 1'b0;
            sticky_snan <= 1'b0;
            sticky_inf  <= 1'b0;
            nan_cnt     <= '0;
            inf_cnt     <= '0;
        end else if (out_hs) begin
            sticky_nan  <= sticky_nan | any_nan;
            sticky_snan <= sticky_snan | any_snan;
            sticky_inf  <= sticky_inf | any_inf;
            nan_cnt     <= nan_next;
            inf_cnt     <= inf_next;
        end
    end

endmodule

// File: tb/tb_fp_class_pipe.sv
// Directed bench for fp_class_pipe: vector table, scoreboard queue, stall/clear/reset sequences.
module tb_fp_class_pipe;

    localparam int LANES = 4;
    localparam int FP_W  = 32;
    localparam int PIPE  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready, in_ready2;
    logic [LANES*FP_W-1:0] in_data;
    logic [LANES-1:0]      in_lane_mask;
    logic                  out_valid, out_valid2;
    logic                  out_ready;
    logic [LANES*6-1:0]    out_class, out_class2;
    logic [LANES-1:0]      out_sign, out_sign2;
    logic [LANES-1:0]      out_max_expo, out_max_expo2;
    logic                  sticky_nan, sticky_snan, sticky_inf;
    logic                  sticky_nan2, sticky_snan2, sticky_inf2;
    logic [15:0]           nan_cnt, inf_cnt;
    logic [1:0]            nan_cnt2, inf_cnt2;
    logic                  stat_clr;

    always #5 clk = ~clk;

    fp_class_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_lane_mask(in_lane_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_class(out_class), .out_sign(out_sign),
        .out_max_expo(out_max_expo), .sticky_nan(sticky_nan), .sticky_snan(sticky_snan),
        .sticky_inf(sticky_inf), .nan_cnt(nan_cnt), .inf_cnt(inf_cnt), .stat_clr(stat_clr)
    );

    fp_class_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_lane_mask(in_lane_mask), .out_valid(out_valid2),
        .out_ready(out_ready), .out_class(out_class2), .out_sign(out_sign2),
        .out_max_expo(out_max_expo2), .sticky_nan(sticky_nan2), .sticky_snan(sticky_snan2),
        .sticky_inf(sticky_inf2), .nan_cnt(nan_cnt2), .inf_cnt(inf_cnt2), .stat_clr(stat_clr)
    );

    typedef struct {
        logic [LANES*FP_W-1:0] data;
        logic [LANES-1:0]      mask;
        logic [LANES*6-1:0]    cls;
        logic [LANES-1:0]      sign;
        logic [LANES-1:0]      maxe;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          beats_out = 0;

    int unsigned nan_m = 0, inf_m = 0, nan2_m = 0;
    logic        stk_nan_m = 1'b0, stk_snan_m = 1'b0, stk_inf_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return {vecs[i].cls, vecs[i].sign, vecs[i].maxe};
    endfunction

    // Scoreboard: compares each delivered beat, then tracks the expected statistics.
    initial begin
        logic        p_rst, p_clr, p_hs, sn, ss, si;
        logic [31:0] e;
        int unsigned pn, pi;
        forever begin
            @(negedge clk);
            #1;
            p_rst = rst;
            p_clr = stat_clr;
            p_hs  = out_valid & out_ready;
            pn = 0; pi = 0; sn = 1'b0; ss = 1'b0; si = 1'b0;
            if (p_hs && !p_rst) begin
                beats_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got class %h expected no beat", out_class);
                end else begin
                    e = exp_q.pop_front();
                    check("out_payload", {out_class, out_sign, out_max_expo}, e);
                    for (int k = 0; k < LANES; k++) begin
                        pn += 32'(e[8+k*6+4] | e[8+k*6+5]);
                        pi += 32'(e[8+k*6+3]);
                        sn |= e[8+k*6+4] | e[8+k*6+5];
                        ss |= e[8+k*6+5];
                        si |= e[8+k*6+3];
                    end
                end
            end
            @(posedge clk);
            if (p_rst || p_clr) begin
                nan_m = 0; inf_m = 0; nan2_m = 0;
                stk_nan_m = 1'b0; stk_snan_m = 1'b0; stk_inf_m = 1'b0;
            end else if (p_hs) begin
                nan_m  = (nan_m + pn > 65535) ? 65535 : nan_m + pn;
                inf_m  = (inf_m + pi > 65535) ? 65535 : inf_m + pi;
                nan2_m = (nan2_m + pn > 3) ? 3 : nan2_m + pn;
                stk_nan_m  |= sn;
                stk_snan_m |= ss;
                stk_inf_m  |= si;
            end
        end
    end

    task automatic drive_beat(input int idx);
        int t;
        @(negedge clk);
        in_valid     = 1'b1;
        in_data      = vecs[idx].data;
        in_lane_mask = vecs[idx].mask;
        #1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 for vector %0d", idx);
        end else
            exp_q.push_back(word(idx));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        #2;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_nan_cnt"}, 32'(nan_cnt), nan_m);
        check({tag, "_inf_cnt"}, 32'(inf_cnt), inf_m);
        check({tag, "_nan_cnt_sat"}, 32'(nan_cnt2), nan2_m);
        check({tag, "_sticky"}, {29'd0, sticky_nan, sticky_snan, sticky_inf},
              {29'd0, stk_nan_m, stk_snan_m, stk_inf_m});
    endtask

    initial begin
        int n;
        int t;
        int b0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_lane_mask = '0;
        out_ready = 1'b1; stat_clr = 1'b0;

        vecs[0] = '{{32'h7F800000, 32'h00000001, 32'h80000000, 32'h3F800000}, 4'hF,
                    {6'b001000, 6'b000010, 6'b000001, 6'b000100}, 4'b0010, 4'b1000};
        vecs[1] = '{{32'h00000000, 32'hFF800000, 32'h7F800001, 32'h7FC00000}, 4'b0111,
                    {6'b000000, 6'b001000, 6'b100000, 6'b010000}, 4'b0100, 4'b0111};
        vecs[2] = '{{32'hFF7FFFFF, 32'h00400000, 32'h7F800000, 32'hFFC00000}, 4'b1010,
                    {6'b000100, 6'b000000, 6'b001000, 6'b000000}, 4'b1000, 4'b0010};
        vecs[3] = '{{4{32'h7FC00000}}, 4'b0000, 24'd0, 4'b0000, 4'b0000};
        vecs[4] = '{{32'hFFC00001, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FC00000}, 4'hF,
                    {4{6'b010000}}, 4'b1010, 4'b1111};
        vecs[5] = '{{32'hFF800001, 32'h7F7FFFFF, 32'h807FFFFF, 32'h00800000}, 4'hF,
                    {6'b100000, 6'b000100, 6'b000010, 6'b000100}, 4'b1010, 4'b1000};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_class", 32'(out_class), 32'd0);
        check("rst_counters", {nan_cnt, inf_cnt}, 32'd0);
        check("rst_sticky", {29'd0, sticky_nan, sticky_snan, sticky_inf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single beat, latency of two cycles
        drive_beat(0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("lat_early_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("lat_out_valid", 32'(out_valid), 32'd1);
        drain();
        check("t1_inf_cnt", 32'(inf_cnt), 32'd1);
        check_stats("t1");

        // NaN lanes and a masked lane
        drive_beat(1);
        idle();
        drain();
        check("t2_nan_cnt", 32'(nan_cnt), 32'd2);
        check("t2_sticky_snan", 32'(sticky_snan), 32'd1);
        check_stats("t2");

        // Whole table back to back
        b0 = beats_out;
        for (int i = 0; i < 6; i++) drive_beat(i);
        idle();
        drain();
        check("table_beats", 32'(beats_out - b0), 32'd6);
        check_stats("table");

        // Clear coincident with a NaN delivery
        drive_beat(4);
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("clr_out_valid", 32'(out_valid), 32'd1);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #2;
        check("clr_nan_cnt", 32'(nan_cnt), 32'd0);
        check("clr_sticky_nan", 32'(sticky_nan), 32'd0);
        check("clr_beat_out", 32'(exp_q.size()), 32'd0);
        check_stats("clr");

        // Counter saturation on the narrow instance
        drive_beat(4);
        drive_beat(4);
        idle();
        drain();
        check("sat_nan_cnt2", 32'(nan_cnt2), 32'd3);
        check("sat_nan_cnt", 32'(nan_cnt), 32'd8);
        drive_beat(4);
        idle();
        drain();
        check("sat_hold_cnt2", 32'(nan_cnt2), 32'd3);
        check_stats("sat");

        // Backpressure with continuous input
        b0 = beats_out;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready    = 1'b0;
            in_valid     = 1'b1;
            in_data      = vecs[n].data;
            in_lane_mask = vecs[n].mask;
            #1;
            if (c >= 3 && exp_q.size() > 0) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", {out_class, out_sign, out_max_expo}, exp_q[0]);
            end
            if (in_ready) begin
                exp_q.push_back(word(n));
                n++;
            end
        end
        check("bp_accepted", 32'(n), 32'(PIPE));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive_beat(2);
        drive_beat(3);
        idle();
        drain();
        check("bp_beats", 32'(beats_out - b0), 32'd4);
        check_stats("bp");

        // Reset with two beats in flight
        out_ready = 1'b0;
        drive_beat(0);
        drive_beat(1);
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_counters", {nan_cnt, inf_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_no_beat", 32'(out_valid), 32'd0);
        drive_beat(5);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("post_rst_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        drain();
        check("post_rst_nan_cnt", 32'(nan_cnt), 32'd1);
        check_stats("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
